mr_move_dma: RTL
================

// Module: mr_move_dma
// PURPOSE
//  Block-move engine for the move-based CPU. It borrows the SRC/DST move bus from the control unit through a HOLD_REQ/HOLD_ACK handshake.
//  Once granted, it performs COUNT read->write moves: it reads from SRC_BASE and writes to DST_BASE.
//  After every MAX_BURST moves it hands the bus back to the control unit for YIELD_CYCLES cycles, so instruction fetch is never starved.
//  It sits beside the control unit. BUS_EN drives the top-level SRC/DST/D_OUT/STO muxes; the existing sto-decoder classifies the DST address.
// PARAMETERS
//  MAX_BURST     8   moves per bus tenure before yielding (>=1)
//  YIELD_CYCLES  2   cycles HOLD_REQ is held low between bursts (>=1)
// PORTS
//  CLK        in   1   system clock, rising edge
//  RST        in   1   asynchronous reset, active-high
//  START      in   1   1-cycle pulse: latch config and begin; ignored while BUSY=1
//  ABORT      in   1   stop the transfer at the next move boundary
//  SRC_BASE   in   16  first source address
//  DST_BASE   in   16  first destination address
//  COUNT      in   16  number of moves (0 legal)
//  SRC_INC    in   1   1: source pointer +1 per move; 0: fixed (IO port)
//  DST_INC    in   1   1: destination pointer +1 per move; 0: fixed
//  HOLD_REQ   out  1   request for the move bus from the control unit
//  HOLD_ACK   in   1   grant from the control unit (given only at a T4 boundary)
//  BUS_EN     out  1   engine owns the bus; top level selects engine SRC/DST/D_OUT/STO
//  SRC        out  16  read address (valid only in RD)
//  DST        out  16  write address (valid only in WR)
//  D_IN       in   16  read data, sampled at the end of RD
//  D_OUT      out  16  write data (valid only in WR)
//  STO        out  1   write strobe, high for exactly the WR cycle
//  BUSY       out  1   state != IDLE
//  DONE       out  1   1-cycle pulse on completion or abort
//  ABORTED    out  1   sticky; set when a transfer ends by ABORT, cleared by the next accepted START
//  REMAIN     out  16  moves not yet written
// BEHAVIOUR
//  Reset: async, state IDLE. Every output and internal register is 0.
//  States and transitions:
//   IDLE:  START & COUNT!=0 -> latch src_ptr, dst_ptr, REMAIN=COUNT, incs, burst=0 -> REQ.
//          START & COUNT==0 -> FIN; no HOLD_REQ, ABORTED=0.
//   REQ:   HOLD_REQ=1. HOLD_ACK=1 -> RD. ABORT -> FIN.
//   RD:    HOLD_REQ=1, BUS_EN=1, SRC=src_ptr. data_reg<=D_IN at the edge -> WR.
//          ABORT -> FIN with no write.
//   WR:    HOLD_REQ=1, BUS_EN=1, DST=dst_ptr, D_OUT=data_reg, STO=1.
//          At the edge: REMAIN-1; src_ptr+=SRC_INC; dst_ptr+=DST_INC; burst+1.
//          Next state: REMAIN reaches 0 or ABORT -> FIN; else burst==MAX_BURST -> YIELD (burst<=0); else RD.
//   YIELD: HOLD_REQ=0, BUS_EN=0 for YIELD_CYCLES cycles -> REQ. ABORT -> FIN.
//   FIN:   HOLD_REQ=0, BUS_EN=0, DONE=1 for one cycle -> IDLE. ABORTED=1 if entered via ABORT.
//  Timing:
//   - HOLD_ACK sampled high in cycle k: RD in cycle k+1, WR in cycle k+2.
//   - Steady state is 2 cycles per move; a back-to-back WR->RD has no bubble.
//  Handshake: HOLD_ACK is ignored outside REQ. The control unit keeps ACK high while HOLD_REQ=1, and the engine does not re-check it.
//  A write is never split: ABORT sampled in WR still completes that STO cycle.
//  Arithmetic: pointers are 16-bit modulo (0xFFFF+1=0x0000). REMAIN never underflows.
//  When SRC, DST, D_OUT and STO are not valid per the above, they are driven 0.
//  Simultaneous events: START and ABORT together in IDLE -> START wins and ABORT is ignored.
//  RST mid-transfer: immediate return to IDLE with all outputs 0; no DONE pulse.
// TESTING
//  1 COUNT=3, SRC=0x0100, DST=0x0200, incs=1, ACK one cycle after REQ
//    -> reads 0x0100..0x0102, writes 0x0200..0x0202 with read data, 3 STO pulses, DONE 1 cycle after last WR, REMAIN=0.
//  2 COUNT=10 with defaults
//    -> 8 moves, HOLD_REQ low exactly 2 cycles, re-REQ, 2 moves, DONE; BUS_EN never high while HOLD_REQ is low.
//  3 SRC_INC=0, SRC=0x00F0, DST=0xFFFE, COUNT=4
//    -> SRC fixed at 0x00F0; DST 0xFFFE, 0xFFFF, 0x0000, 0x0001.
//  4 START with COUNT=0
//    -> DONE 1 cycle later, HOLD_REQ never high, ABORTED=0.
//  5 COUNT=5, ABORT during the WR of move 2
//    -> 2 STO pulses total, DONE, ABORTED=1, REMAIN=3; next START clears ABORTED.
//  6 RST during RD; START pulse while BUSY
//    -> on RST, outputs 0 asynchronously, IDLE, no DONE; the START pulse while BUSY leaves REMAIN and the pointers unchanged.

Source files
------------

// File: rtl/mr_move_dma.sv
// rtl/mr_move_dma.sv - block-move DMA engine that borrows the SRC/DST move bus via HOLD_REQ/HOLD_ACK
module mr_move_dma #(
  parameter int MAX_BURST    = 8,
  parameter int YIELD_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [15:0] SRC_BASE,
  input  logic [15:0] DST_BASE,
  input  logic [15:0] COUNT,
  input  logic        SRC_INC,
  input  logic        DST_INC,
  output logic        HOLD_REQ,
  input  logic        HOLD_ACK,
  output logic        BUS_EN,
  output logic [15:0] SRC,
  output logic [15:0] DST,
  input  logic [15:0] D_IN,
  output logic [15:0] D_OUT,
  output logic        STO,
  output logic        BUSY,
  output logic        DONE,
  output logic        ABORTED,
  output logic [15:0] REMAIN
);

  // IDLE must encode as 0 so that reset leaves every output low.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RD    = 3'd2,
    S_WR    = 3'd3,
    S_YIELD = 3'd4,
    S_FIN   = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] src_ptr_q, src_ptr_d;
  logic [15:0] dst_ptr_q, dst_ptr_d;
  logic [15:0] remain_q, remain_d;
  logic [15:0] data_q, data_d;
  logic [15:0] burst_q, burst_d;
  logic [15:0] yield_cnt_q, yield_cnt_d;
  logic        src_inc_q, src_inc_d;
  logic        dst_inc_q, dst_inc_d;
  logic        aborted_q, aborted_d;

  // State and datapath registers; asynchronous reset clears everything.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      src_ptr_q   <= 16'd0;
      dst_ptr_q   <= 16'd0;
      remain_q    <= 16'd0;
      data_q      <= 16'd0;
      burst_q     <= 16'd0;
      yield_cnt_q <= 16'd0;
      src_inc_q   <= 1'b0;
      dst_inc_q   <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_ptr_q   <= src_ptr_d;
      dst_ptr_q   <= dst_ptr_d;
      remain_q    <= remain_d;
      data_q      <= data_d;
      burst_q     <= burst_d;
      yield_cnt_q <= yield_cnt_d;
      src_inc_q   <= src_inc_d;
      dst_inc_q   <= dst_inc_d;
      aborted_q   <= aborted_d;
    end
  end

  // Next-state and datapath updates; ABORT is only honoured at move boundaries.
  always_comb begin
    state_d     = state_q;
    src_ptr_d   = src_ptr_q;
    dst_ptr_d   = dst_ptr_q;
    remain_d    = remain_q;
    data_d      = data_q;
    burst_d     = burst_q;
    yield_cnt_d = yield_cnt_q;
    src_inc_d   = src_inc_q;
    dst_inc_d   = dst_inc_q;
    aborted_d   = aborted_q;
    case (state_q)
      S_IDLE: begin
        // START beats a simultaneous ABORT: ABORT is not looked at here.
        if (START) begin
          src_ptr_d = SRC_BASE;
          dst_ptr_d = DST_BASE;
          remain_d  = COUNT;
          src_inc_d = SRC_INC;
          dst_inc_d = DST_INC;
          burst_d   = 16'd0;
          aborted_d = 1'b0;
          state_d   = (COUNT != 16'd0) ? S_REQ : S_FIN;
        end
      end
      S_REQ: begin
        if (ABORT) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else if (HOLD_ACK) begin
          state_d = S_RD;
        end
      end
      S_RD: begin
        data_d = D_IN;
        if (ABORT) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else begin
          state_d = S_WR;
        end
      end
      S_WR: begin
        // The write in this cycle always completes, even when ABORT is high.
        if (remain_q != 16'd0) remain_d = remain_q - 16'd1;
        src_ptr_d = src_ptr_q + {15'd0, src_inc_q};
        dst_ptr_d = dst_ptr_q + {15'd0, dst_inc_q};
        burst_d   = burst_q + 16'd1;
        if (remain_d == 16'd0) begin
          state_d = S_FIN;
        end else if (ABORT) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else if (burst_d == 16'(MAX_BURST)) begin
          burst_d     = 16'd0;
          yield_cnt_d = 16'd0;
          state_d     = S_YIELD;
        end else begin
          state_d = S_RD;
        end
      end
      S_YIELD: begin
        if (ABORT) begin
          aborted_d = 1'b1;
          state_d   = S_FIN;
        end else if (yield_cnt_q == 16'(YIELD_CYCLES - 1)) begin
          state_d = S_REQ;
        end else begin
          yield_cnt_d = yield_cnt_q + 16'd1;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Bus-side outputs decode straight from state so they drop with async reset.
  assign HOLD_REQ = (state_q == S_REQ) || (state_q == S_RD) || (state_q == S_WR);
  assign BUS_EN   = (state_q == S_RD) || (state_q == S_WR);
  assign SRC      = (state_q == S_RD) ? src_ptr_q : 16'd0;
  assign DST      = (state_q == S_WR) ? dst_ptr_q : 16'd0;
  assign D_OUT    = (state_q == S_WR) ? data_q : 16'd0;
  assign STO      = (state_q == S_WR);
  assign BUSY     = (state_q != S_IDLE);
  assign DONE     = (state_q == S_FIN);
  assign ABORTED  = aborted_q;
  assign REMAIN   = remain_q;

endmodule
